// File: rtl/multiword_add_seq_pkg.sv
// Shared types and defaults for the multiword sequential adder.
// Holds the FSM state encoding and default word width/count.
package multiword_add_seq_pkg;

  localparam int W_DEF       = 4;
  localparam int N_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_seq_if.sv
// Request/result bundle for multiword_add_seq.
// master: start, a, b, cin (sub with MWADD_SUB_EN) out; busy, done, sum, cout in.
interface multiword_add_seq_if
  import multiword_add_seq_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int N_WORDS = N_WORDS_DEF
) ();

  localparam int TW = W * N_WORDS;

  logic          start;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          cin;
`ifdef MWADD_SUB_EN
  logic          sub;
`endif
  logic          busy;
  logic          done;
  logic [TW-1:0] sum;
  logic          cout;

  modport master (
`ifdef MWADD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef MWADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/multiword_add_seq_rca_slice.sv
// W-bit ripple-carry adder slice built from bit-level full adders.
// Ports: a, b, cin in; sum, cout out. Purely combinational.
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential W*N_WORDS adder reusing one W-bit slice, LS word first.
// Ports: clk, rst (sync, active-high), bus (slave). Option: MWADD_SUB_EN.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int N_WORDS = N_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  multiword_add_seq_if.slave bus
);

  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);

  state_t state;
  state_t state_nx;

  logic [IW-1:0]               idx;
  logic [N_WORDS-1:0][W-1:0]   a_reg;
  logic [N_WORDS-1:0][W-1:0]   b_reg;
  logic [N_WORDS-1:0][W-1:0]   sum_reg;
  logic                        carry;
  logic                        cout_reg;

  logic [W-1:0]                sl_s;
  logic                        sl_c;
  logic                        is_last;

  logic [W*N_WORDS-1:0]        b_in;
  logic                        c_in;

  // Subtraction is a + ~b + 1, so it folds into the capture.
`ifdef MWADD_SUB_EN
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  assign is_last = (idx == LAST);

  rca_slice #(
    .W (W)
  ) u_slice (
    .a    (a_reg[idx]),
    .b    (b_reg[idx]),
    .cin  (carry),
    .sum  (sl_s),
    .cout (sl_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (is_last)   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg   <= bus.a;
            b_reg   <= b_in;
            carry   <= c_in;
            idx     <= '0;
            sum_reg <= '0;
          end
        end
        RUN: begin
          sum_reg[idx] <= sl_s;
          carry        <= sl_c;
          if (is_last) cout_reg <= sl_c;
          else         idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: vector table, corner
// sequences and random operands against an arithmetic reference.
module tb_multiword_add_seq;
  import multiword_add_seq_pkg::*;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int TW = W * N;

  logic clk;
  logic rst;

  multiword_add_seq_if #(.W(W), .N_WORDS(N)) bus ();

  multiword_add_seq #(.W(W), .N_WORDS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic          sub;
    logic [TW-1:0] s;
    logic          co;
    string         nm;
  } vec_t;

  vec_t tbl[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [TW:0] act,
                     input logic [TW:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the whole operands.
  function automatic logic [TW:0] model(input logic [TW-1:0] av,
                                        input logic [TW-1:0] bv,
                                        input logic c, input logic s);
    logic [TW:0] r;
    if (s) r = {1'b0, av} + {1'b0, ~bv} + (TW+1)'(1);
    else   r = {1'b0, av} + {1'b0, bv} + (TW+1)'(c);
    return r;
  endfunction

  // Starts one operation in the current (idle) cycle. poke>0 raises an
  // extra start with different operands in that cycle of the run.
  task automatic do_op(input logic [TW-1:0] av, input logic [TW-1:0] bv,
                       input logic c, input logic s,
                       input logic [TW-1:0] es, input logic ec,
                       input int poke, input string nm);
    int terr;
    logic [TW-1:0] aa;
    terr = 0;
    aa = {(TW/4){4'hA}};
    bus.a = av;
    bus.b = bv;
    bus.cin = c;
`ifdef MWADD_SUB_EN
    bus.sub = s;
`endif
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.a = TW'($urandom);
    bus.b = TW'($urandom);
    bus.cin = ~c;
`ifdef MWADD_SUB_EN
    bus.sub = ~s;
`endif
    for (int cyc = 1; cyc <= N + 1; cyc++) begin
      if (cyc == poke) begin
        bus.start = 1'b1;
        bus.a = aa;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy !== 1'b1) terr++;
      if (bus.done !== (cyc == N + 1)) terr++;
      if (cyc == 1 && bus.sum !== '0) terr++;
      if (cyc < N + 1) tick;
    end
    chk({nm, " timing"}, (TW+1)'(terr), '0);
    chk({nm, " sum"}, {1'b0, bus.sum}, {1'b0, es});
    chk({nm, " cout"}, (TW+1)'(bus.cout), (TW+1)'(ec));
    tick;
    bus.start = 1'b0;
    chk({nm, " idle"}, {bus.busy, bus.done, bus.sum, bus.cout},
        {2'b00, es, ec});
  endtask

  initial begin
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic          rc;
    logic          rs;
    logic [TW:0]   m;
    int            ndone;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
`ifdef MWADD_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (3) tick;
    chk("reset", {bus.busy, bus.done, bus.sum, bus.cout}, '0);
    rst = 1'b0;
    tick;
    chk("post reset busy", (TW+1)'(bus.busy), '0);

    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "wrap"});
    tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "nocarry"});
    tbl.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, "cin only"});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "all ones"});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, "top carry"});
    tbl.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, "ripple"});
`ifdef MWADD_SUB_EN
    tbl.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, "sub borrow"});
    tbl.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, "sub ok"});
`endif

    // Consecutive ops start in the cycle right after done.
    foreach (tbl[i])
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
            tbl[i].s, tbl[i].co, 0, tbl[i].nm);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 2, "busy start");
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, N + 1, "done start");
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 0, "back2back");

    // Reset in the middle of a run.
    bus.a = 16'hFFFF;
    bus.b = 16'h0001;
    bus.cin = 1'b0;
`ifdef MWADD_SUB_EN
    bus.sub = 1'b0;
`endif
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("mid reset", {bus.busy, bus.done, bus.sum, bus.cout}, '0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    chk("no done after reset", (TW+1)'(ndone), '0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, "after reset");

    for (int i = 0; i < 25; i++) begin
      ra = TW'($urandom);
      rb = TW'($urandom);
      rc = 1'($urandom);
`ifdef MWADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      m = model(ra, rb, rc, rs);
      do_op(ra, rb, rc, rs, m[TW-1:0], m[TW], 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
